// File: rtl/apu_status_reader_if.sv
// CPU register-window bus between the CPU (master) and the APU status reader (slave).
interface apu_status_reader_if;
  logic [15:0] reg_addr;
  logic [7:0]  reg_data_in;
  logic        reg_en;
  logic        reg_we;
  logic [7:0]  reg_data_out;
  logic        reg_data_valid;

  modport master (
    output reg_addr, reg_data_in, reg_en, reg_we,
    input  reg_data_out, reg_data_valid
  );

  modport slave (
    input  reg_addr, reg_data_in, reg_en, reg_we,
    output reg_data_out, reg_data_valid
  );
endinterface

// File: rtl/apu_status_reader.sv
// Read-side responder for $4015/$4016/$4017: status, controller serial ports,
// frame/DMC IRQ flags and the CPU IRQ line.
module apu_status_reader (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      cpu_clk_en,
  apu_status_reader_if.slave        bus,
  input  logic [3:0]                length_nonzero,
  input  logic                      dmc_active,
  input  logic                      frame_irq_set,
  input  logic                      frame_irq_inhibit,
  input  logic                      dmc_irq_set,
  input  logic [7:0]                ctrl1_buttons,
  input  logic [7:0]                ctrl2_buttons,
  output logic                      irq_l
);

  logic       frame_irq_r, dmc_irq_r, strobe_r, valid_r, irq_l_r;
  logic [7:0] sh1_r, sh2_r, data_r;

  logic       rd_s, wr_s, sel_4015_s, sel_4016_s, sel_4017_s;
  logic       frame_nxt_s, dmc_nxt_s, strobe_nxt_s, valid_nxt_s, hit_s;
  logic [7:0] sh1_nxt_s, sh2_nxt_s, data_nxt_s;

  // Decode strobes and compute next state from pre-edge flag/shift values.
  always_comb begin
    rd_s         = cpu_clk_en & bus.reg_en & ~bus.reg_we;
    wr_s         = cpu_clk_en & bus.reg_en & bus.reg_we;
    sel_4015_s   = (bus.reg_addr == 16'h4015);
    sel_4016_s   = (bus.reg_addr == 16'h4016);
    sel_4017_s   = (bus.reg_addr == 16'h4017);
    frame_nxt_s  = frame_irq_r;
    dmc_nxt_s    = dmc_irq_r;
    strobe_nxt_s = strobe_r;
    sh1_nxt_s    = sh1_r;
    sh2_nxt_s    = sh2_r;
    data_nxt_s   = data_r;
    hit_s        = 1'b0;
    valid_nxt_s  = valid_r;

    // Set has priority over a coincident clear.
    if (cpu_clk_en & frame_irq_set & ~frame_irq_inhibit) begin
      frame_nxt_s = 1'b1;
    end else if ((rd_s & sel_4015_s) | (wr_s & sel_4017_s & bus.reg_data_in[6])) begin
      frame_nxt_s = 1'b0;
    end else begin
      frame_nxt_s = frame_irq_r;
    end

    if (cpu_clk_en & dmc_irq_set) begin
      dmc_nxt_s = 1'b1;
    end else if (wr_s & sel_4015_s) begin
      dmc_nxt_s = 1'b0;
    end else begin
      dmc_nxt_s = dmc_irq_r;
    end

    if (wr_s & sel_4016_s) begin
      strobe_nxt_s = bus.reg_data_in[0];
    end else begin
      strobe_nxt_s = strobe_r;
    end

    // Reload uses the strobe value held before this edge's write.
    if (cpu_clk_en & strobe_r) begin
      sh1_nxt_s = ctrl1_buttons;
      sh2_nxt_s = ctrl2_buttons;
    end else begin
      if (rd_s & sel_4016_s) begin
        sh1_nxt_s = {1'b1, sh1_r[7:1]};
      end else begin
        sh1_nxt_s = sh1_r;
      end
      if (rd_s & sel_4017_s) begin
        sh2_nxt_s = {1'b1, sh2_r[7:1]};
      end else begin
        sh2_nxt_s = sh2_r;
      end
    end

    if (rd_s) begin
      case (bus.reg_addr)
        16'h4015: begin
          data_nxt_s = {dmc_irq_r, frame_irq_r, 1'b0, dmc_active, length_nonzero};
          hit_s      = 1'b1;
        end
        16'h4016: begin
          data_nxt_s = {7'b0100000, (strobe_r ? ctrl1_buttons[0] : sh1_r[0])};
          hit_s      = 1'b1;
        end
        16'h4017: begin
          data_nxt_s = {7'b0100000, (strobe_r ? ctrl2_buttons[0] : sh2_r[0])};
          hit_s      = 1'b1;
        end
        default: begin
          data_nxt_s = data_r;
          hit_s      = 1'b0;
        end
      endcase
    end else begin
      data_nxt_s = data_r;
      hit_s      = 1'b0;
    end

    if (cpu_clk_en) begin
      valid_nxt_s = hit_s;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // State registers; irq_l follows the registered flags one clk later.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      frame_irq_r <= 1'b0;
      dmc_irq_r   <= 1'b0;
      strobe_r    <= 1'b0;
      sh1_r       <= 8'h00;
      sh2_r       <= 8'h00;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      irq_l_r     <= 1'b1;
    end else begin
      frame_irq_r <= frame_nxt_s;
      dmc_irq_r   <= dmc_nxt_s;
      strobe_r    <= strobe_nxt_s;
      sh1_r       <= sh1_nxt_s;
      sh2_r       <= sh2_nxt_s;
      data_r      <= data_nxt_s;
      valid_r     <= valid_nxt_s;
      irq_l_r     <= ~(frame_irq_r | dmc_irq_r);
    end
  end

  assign bus.reg_data_out   = data_r;
  assign bus.reg_data_valid = valid_r;
  assign irq_l              = irq_l_r;

endmodule
